// File: rtl/stick_game_ctrl.sv
// Game-control stage for the falling-stick game. It runs the idle / countdown /
// play / game-over sequence, drops one stick at a time and keeps score, misses,
// difficulty and remaining time. Every output comes straight from a register.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; difficulty may be adjusted
// COUNT  | 3-2-1 countdown, one digit per second of frame ticks
// PLAY   | timed play: sticks spawn, fall, get caught or missed
// OVER   | results held; start returns to IDLE
module stick_game_ctrl #(
    parameter int         NUM_STICKS     = 8,
    parameter int         Y_REST         = 300,
    parameter int         Y_FLOOR        = 570,
    parameter int         FRAMES_PER_SEC = 60,
    parameter int         GAME_SECONDS   = 60,
    parameter int         SPAWN_FRAMES   = 30,
    parameter int         MAX_MISSES     = 3,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     frame_tick,
    input  logic                     start_pulse,
    input  logic                     diff_up_pulse,
    input  logic                     diff_down_pulse,
    input  logic [NUM_STICKS-1:0]    catch_pulse,
    output logic [1:0]               state,
    output logic [2:0]               difficulty,
    output logic [1:0]               countdown,
    output logic [10*NUM_STICKS-1:0] stick_y,
    output logic [7:0]               score,
    output logic [1:0]               misses,
    output logic [6:0]               time_left
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [9:0]  REST     = 10'(Y_REST);
    localparam logic [10:0] FLOOR    = 11'(Y_FLOOR);
    localparam logic [5:0]  DIV_LAST = 6'(FRAMES_PER_SEC - 1);
    localparam logic [6:0]  GAME_T   = 7'(GAME_SECONDS);
    localparam logic [4:0]  SPAWN_T  = 5'(SPAWN_FRAMES);
    localparam logic [1:0]  MISS_LIM = 2'(MAX_MISSES);

    state_t                         state_q, state_d;
    logic [2:0]                     diff_q, diff_d;
    logic [1:0]                     cd_q, cd_d;
    logic [NUM_STICKS-1:0][9:0]     stick_q, stick_d;
    logic [7:0]                     score_q, score_d;
    logic [1:0]                     misses_q, misses_d;
    logic [6:0]                     time_q, time_d;
    logic [5:0]                     div_q, div_d;
    logic [4:0]                     spawn_q, spawn_d;
    logic                           active_q, active_d;
    logic [2:0]                     idx_q, idx_d;
    logic [7:0]                     lfsr_q, lfsr_d;

    logic        lfsr_fb;
    logic [10:0] new_y;
    logic        catch_hit;
    logic        catch_any;
    logic        div_wrap;
    logic [1:0]  miss_cnt;

    assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    // 11 bits so a stick near the bottom cannot wrap back to the top.
    assign new_y     = {1'b0, stick_q[idx_q]} + {8'b0, diff_q};
    assign catch_hit = active_q && catch_pulse[idx_q];
    assign catch_any = |catch_pulse;
    assign div_wrap  = frame_tick && (div_q == DIV_LAST);
    assign miss_cnt  = misses_q + 2'd1;

    // State register and all game registers; reset aborts any game in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            diff_q   <= 3'd1;
            cd_q     <= 2'd0;
            stick_q  <= {NUM_STICKS{REST}};
            score_q  <= 8'd0;
            misses_q <= 2'd0;
            time_q   <= 7'd0;
            div_q    <= 6'd0;
            spawn_q  <= 5'd0;
            active_q <= 1'b0;
            idx_q    <= 3'd0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            diff_q   <= diff_d;
            cd_q     <= cd_d;
            stick_q  <= stick_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            time_q   <= time_d;
            div_q    <= div_d;
            spawn_q  <= spawn_d;
            active_q <= active_d;
            idx_q    <= idx_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // Next-state and register updates for every game phase.
    always_comb begin
        state_d  = state_q;
        diff_d   = diff_q;
        cd_d     = cd_q;
        stick_d  = stick_q;
        score_d  = score_q;
        misses_d = misses_q;
        time_d   = time_q;
        div_d    = div_q;
        spawn_d  = spawn_q;
        active_d = active_q;
        idx_d    = idx_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_fb};

        case (state_q)
            S_IDLE: begin
                if (diff_up_pulse && !diff_down_pulse && diff_q != 3'd7) begin
                    diff_d = diff_q + 3'd1;
                end else if (diff_down_pulse && !diff_up_pulse && diff_q != 3'd1) begin
                    diff_d = diff_q - 3'd1;
                end
                if (start_pulse) begin
                    state_d = S_COUNT;
                    cd_d    = 2'd3;
                    div_d   = 6'd0;
                end
            end

            S_COUNT: begin
                if (frame_tick) begin
                    if (div_wrap) begin
                        div_d = 6'd0;
                        if (cd_q == 2'd1) begin
                            state_d  = S_PLAY;
                            cd_d     = 2'd0;
                            score_d  = 8'd0;
                            misses_d = 2'd0;
                            time_d   = GAME_T;
                            stick_d  = {NUM_STICKS{REST}};
                            spawn_d  = SPAWN_T;
                            active_d = 1'b0;
                        end else begin
                            cd_d = cd_q - 2'd1;
                        end
                    end else begin
                        div_d = div_q + 6'd1;
                    end
                end
            end

            S_PLAY: begin
                if (frame_tick) begin
                    div_d = div_wrap ? 6'd0 : div_q + 6'd1;
                    if (div_wrap) begin
                        time_d = time_q - 7'd1;
                    end
                    if (!active_q) begin
                        if (spawn_q <= 5'd1) begin
                            spawn_d  = 5'd0;
                            active_d = 1'b1;
                            idx_d    = lfsr_q[2:0];
                        end else begin
                            spawn_d = spawn_q - 5'd1;
                        end
                    end else if (!catch_hit) begin
                        // A catch in the same cycle pre-empts the fall, so no miss.
                        if (new_y >= FLOOR) begin
                            stick_d[idx_q] = REST;
                            misses_d       = miss_cnt;
                            active_d       = 1'b0;
                            spawn_d        = SPAWN_T;
                            if (miss_cnt == MISS_LIM) begin
                                state_d = S_OVER;
                            end
                        end else begin
                            stick_d[idx_q] = new_y[9:0];
                        end
                    end
                end

                if (catch_hit) begin
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    stick_d[idx_q] = REST;
                    active_d       = 1'b0;
                    spawn_d        = SPAWN_T;
                end else if (catch_any && score_q != 8'd0) begin
                    score_d = score_q - 8'd1;
                end

                // Time expiry is applied after the catch so a last-moment catch still scores.
                if (div_wrap && time_q <= 7'd1) begin
                    state_d  = S_OVER;
                    stick_d  = {NUM_STICKS{REST}};
                    active_d = 1'b0;
                end
            end

            S_OVER: begin
                if (start_pulse) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state      = state_q;
    assign difficulty = diff_q;
    assign countdown  = cd_q;
    assign stick_y    = stick_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign time_left  = time_q;

endmodule

// File: tb/tb_stick_game_ctrl.sv
// Scoreboard bench for stick_game_ctrl: the stimulus process queues expected
// output values tagged with the cycle they apply to, and a monitor process
// pops and compares them against the DUT outputs.
module tb_stick_game_ctrl;

    localparam int F_STATE = 0;
    localparam int F_DIFF  = 1;
    localparam int F_CD    = 2;
    localparam int F_STICK = 3;
    localparam int F_SCORE = 4;
    localparam int F_MISS  = 5;
    localparam int F_TIME  = 6;

    typedef struct {
        int cyc;
        int fid;
        int sub;
        int val;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        frame_tick;
    logic        start_pulse;
    logic        diff_up_pulse;
    logic        diff_down_pulse;
    logic [7:0]  catch_pulse;
    logic [1:0]  state;
    logic [2:0]  difficulty;
    logic [1:0]  countdown;
    logic [79:0] stick_y;
    logic [7:0]  score;
    logic [1:0]  misses;
    logic [6:0]  time_left;

    exp_t sb[$];
    exp_t mon_e;
    int   mon_act;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc_cnt = 0;
    logic [7:0] m_lfsr;
    logic [7:0] lf_at;
    logic [7:0] tlf;
    logic [2:0] idx0, idx1, ib, ic;

    stick_game_ctrl dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_tick      (frame_tick),
        .start_pulse     (start_pulse),
        .diff_up_pulse   (diff_up_pulse),
        .diff_down_pulse (diff_down_pulse),
        .catch_pulse     (catch_pulse),
        .state           (state),
        .difficulty      (difficulty),
        .countdown       (countdown),
        .stick_y         (stick_y),
        .score           (score),
        .misses          (misses),
        .time_left       (time_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference LFSR (Fibonacci, taps 8,6,5,4) to predict which stick spawns.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 8'hA5;
        else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic string fname(input int fid);
        case (fid)
            F_STATE: return "state";
            F_DIFF:  return "difficulty";
            F_CD:    return "countdown";
            F_STICK: return "stick_y";
            F_SCORE: return "score";
            F_MISS:  return "misses";
            default: return "time_left";
        endcase
    endfunction

    function automatic int field(input int fid, input int sub);
        case (fid)
            F_STATE: return int'(state);
            F_DIFF:  return int'(difficulty);
            F_CD:    return int'(countdown);
            F_STICK: return int'(stick_y[sub*10 +: 10]);
            F_SCORE: return int'(score);
            F_MISS:  return int'(misses);
            default: return int'(time_left);
        endcase
    endfunction

    function automatic logic [7:0] bitmask(input logic [2:0] i);
        logic [7:0] one;
        one = 8'h01;
        return one << i;
    endfunction

    // Monitor: outputs are compared shortly after each falling clock edge or reset assertion.
    always begin
        @(negedge clk or negedge reset_n);
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            mon_e   = sb.pop_front();
            mon_act = field(mon_e.fid, mon_e.sub);
            n_total = n_total + 1;
            if (mon_act == mon_e.val) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL %s[%0d] at cycle %0d: got %0d, expected %0d",
                         fname(mon_e.fid), mon_e.sub, mon_e.cyc, mon_act, mon_e.val);
            end
        end
    end

    task automatic chk(input int fid, input int sub, input int val);
        exp_t e;
        e.cyc = cyc_cnt;
        e.fid = fid;
        e.sub = sub;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk_rest();
        for (int i = 0; i < 8; i++) chk(F_STICK, i, 300);
    endtask

    task automatic step(input logic ft, input logic st, input logic up,
                        input logic dn, input logic [7:0] ct);
        frame_tick      = ft;
        start_pulse     = st;
        diff_up_pulse   = up;
        diff_down_pulse = dn;
        catch_pulse     = ct;
        lf_at           = m_lfsr;
        @(posedge clk);
        #1;
        frame_tick      = 1'b0;
        start_pulse     = 1'b0;
        diff_up_pulse   = 1'b0;
        diff_down_pulse = 1'b0;
        catch_pulse     = 8'h00;
    endtask

    task automatic tick(input logic [7:0] ct);
        step(1'b1, 1'b0, 1'b0, 1'b0, ct);
        tlf = lf_at;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(8'h00);
    endtask

    initial begin
        reset_n         = 1'b0;
        frame_tick      = 1'b0;
        start_pulse     = 1'b0;
        diff_up_pulse   = 1'b0;
        diff_down_pulse = 1'b0;
        catch_pulse     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk(F_STATE, 0, 0); chk(F_DIFF, 0, 1); chk(F_CD, 0, 0);
        chk(F_SCORE, 0, 0); chk(F_MISS, 0, 0); chk(F_TIME, 0, 0);
        chk_rest();
        n_total = n_total + 1;
        if (state == 2'd0 && difficulty == 3'd1) n_pass = n_pass + 1;
        else $display("FAIL direct reset check: state=%0d difficulty=%0d", state, difficulty);

        // Difficulty saturation.
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 1, 0, 8'h00);
            chk(F_DIFF, 0, (k + 1 > 7) ? 7 : k + 1);
        end
        n_total = n_total + 1;
        if (difficulty == 3'd7) n_pass = n_pass + 1;
        else $display("FAIL direct difficulty max: got %0d", difficulty);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 1, 8'h00);
            chk(F_DIFF, 0, (7 - k < 1) ? 1 : 7 - k);
        end
        n_total = n_total + 1;
        if (difficulty == 3'd1) n_pass = n_pass + 1;
        else $display("FAIL direct difficulty min: got %0d", difficulty);
        step(0, 0, 1, 0, 8'h00); chk(F_DIFF, 0, 2);
        step(0, 0, 1, 1, 8'h00); chk(F_DIFF, 0, 2);

        // Countdown.
        step(0, 1, 0, 0, 8'h00);
        chk(F_STATE, 0, 1); chk(F_CD, 0, 3);
        for (int k = 1; k <= 180; k++) begin
            tick(8'h00);
            case (k)
                59, 60:   chk(F_CD, 0, (k == 59) ? 3 : 2);
                119, 120: chk(F_CD, 0, (k == 119) ? 2 : 1);
                179: begin chk(F_CD, 0, 1); chk(F_STATE, 0, 1); end
                180: begin
                    chk(F_STATE, 0, 2); chk(F_CD, 0, 0); chk(F_TIME, 0, 60);
                    chk(F_SCORE, 0, 0); chk(F_MISS, 0, 0);
                end
                default: ;
            endcase
        end
        n_total = n_total + 1;
        if (state == 2'd2 && time_left == 7'd60) n_pass = n_pass + 1;
        else $display("FAIL direct play entry: state=%0d time_left=%0d", state, time_left);

        // Game A, difficulty 2: catch, spawn spacing, wrong presses, floor tie, time expiry.
        ticks(29);
        tick(8'h00); idx0 = tlf[2:0];
        tick(8'h00); chk(F_STICK, idx0, 302);
        ticks(9);    chk(F_STICK, idx0, 320);
        step(0, 0, 0, 0, bitmask(idx0));
        chk(F_SCORE, 0, 1); chk(F_STICK, idx0, 300);
        ticks(29);
        tick(8'h00); idx1 = tlf[2:0];
        chk_rest();
        tick(8'h00); chk(F_STICK, idx1, 302); chk(F_TIME, 0, 59);
        step(0, 0, 0, 0, bitmask(idx1 + 3'd1));
        chk(F_SCORE, 0, 0); chk(F_STICK, idx1, 302);
        step(0, 0, 0, 0, bitmask(idx1 + 3'd1));
        chk(F_SCORE, 0, 0);
        ticks(133);
        chk(F_STICK, idx1, 568); chk(F_MISS, 0, 0);
        tick(bitmask(idx1));
        chk(F_SCORE, 0, 1); chk(F_MISS, 0, 0); chk(F_STICK, idx1, 300); chk(F_STATE, 0, 2);
        for (int m = 0; m < 112; m++) begin
            ticks(30);
            if (m == 0) begin
                step(0, 1, 1, 0, 8'h00);
                chk(F_DIFF, 0, 2); chk(F_STATE, 0, 2);
            end
            step(0, 0, 0, 0, 8'hFF);
            chk(F_SCORE, 0, m + 2);
        end
        ticks(34);
        chk(F_TIME, 0, 1); chk(F_STATE, 0, 2);
        tick(8'hFF);
        chk(F_SCORE, 0, 114); chk(F_STATE, 0, 3); chk(F_TIME, 0, 0); chk(F_MISS, 0, 0);
        chk_rest();
        step(0, 1, 0, 0, 8'h00);
        chk(F_STATE, 0, 0); chk(F_SCORE, 0, 114); chk(F_DIFF, 0, 2);

        // Game B, difficulty 7: one catch then three misses.
        repeat (5) step(0, 0, 1, 0, 8'h00);
        chk(F_DIFF, 0, 7);
        step(0, 1, 0, 0, 8'h00);
        ticks(180);
        chk(F_STATE, 0, 2); chk(F_SCORE, 0, 0); chk(F_TIME, 0, 60);
        ticks(29);
        tick(8'h00); ib = tlf[2:0];
        step(0, 0, 0, 0, bitmask(ib));
        chk(F_SCORE, 0, 1);
        ticks(29);
        tick(8'h00); ib = tlf[2:0];
        ticks(38);
        chk(F_STICK, ib, 566); chk(F_MISS, 0, 0);
        tick(8'h00);
        chk(F_MISS, 0, 1); chk(F_STICK, ib, 300); chk(F_STATE, 0, 2);
        ticks(68); chk(F_MISS, 0, 1);
        tick(8'h00); chk(F_MISS, 0, 2);
        ticks(68); chk(F_MISS, 0, 2); chk(F_STATE, 0, 2);
        tick(8'h00);
        chk(F_MISS, 0, 3); chk(F_STATE, 0, 3); chk(F_TIME, 0, 57);
        chk_rest();
        step(0, 1, 0, 0, 8'h00);
        chk(F_STATE, 0, 0); chk(F_SCORE, 0, 1); chk(F_MISS, 0, 3);
        n_total = n_total + 1;
        if (score == 8'd1 && misses == 2'd3) n_pass = n_pass + 1;
        else $display("FAIL direct held results: score=%0d misses=%0d", score, misses);

        // Game C, difficulty 5: asynchronous reset while a stick is at 450.
        repeat (2) step(0, 0, 0, 1, 8'h00);
        chk(F_DIFF, 0, 5);
        step(0, 1, 0, 0, 8'h00);
        ticks(180);
        ticks(29);
        tick(8'h00); ic = tlf[2:0];
        ticks(30);
        chk(F_STICK, ic, 450); chk(F_TIME, 0, 59);
        #6;
        reset_n = 1'b0;
        chk(F_STATE, 0, 0); chk(F_DIFF, 0, 1); chk(F_STICK, ic, 300);
        chk(F_TIME, 0, 0); chk(F_SCORE, 0, 0); chk(F_MISS, 0, 0); chk(F_CD, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 8'h00);
        chk(F_STATE, 0, 0); chk(F_DIFF, 0, 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        while (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            n_total = n_total + 1;
            $display("FAIL %s[%0d] never compared (queued at cycle %0d), expected %0d",
                     fname(mon_e.fid), mon_e.sub, mon_e.cyc, mon_e.val);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
